// File: rtl/tone_pkg.sv
// ---------------------------------------------------------------------------
// tone_pkg
// Shared constants for the tone datapath: the sine clkgen divider values for
// the melody pitches, note durations in samples at fs = 8 kHz, field width
// defaults and the melody sequencer FSM state type.
// ---------------------------------------------------------------------------
package tone_pkg;

    localparam int unsigned PW_DEF = 5;    // pitch (divider maxval) field width
    localparam int unsigned DW_DEF = 13;   // duration field width in samples

    // Divider values for the sine clkgen; a code of 0 denotes a rest.
    localparam logic [PW_DEF-1:0] D     = 5'd27;
    localparam logic [PW_DEF-1:0] E     = 5'd24;
    localparam logic [PW_DEF-1:0] Fis   = 5'd21;
    localparam logic [PW_DEF-1:0] G     = 5'd20;
    localparam logic [PW_DEF-1:0] A     = 5'd18;
    localparam logic [PW_DEF-1:0] B     = 5'd16;
    localparam logic [PW_DEF-1:0] C     = 5'd15;
    localparam logic [PW_DEF-1:0] Dhigh = 5'd13;

    // Note lengths in samples at 8 kHz.
    localparam logic [DW_DEF-1:0] N_EIGHTH         = 13'd1000;
    localparam logic [DW_DEF-1:0] N_QUARTER        = 13'd2000;
    localparam logic [DW_DEF-1:0] N_DOTTED_QUARTER = 13'd3000;
    localparam logic [DW_DEF-1:0] N_HALF           = 13'd4000;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_FETCH,
        ST_PLAY,
        ST_DONE
    } seq_state_e;

endpackage

// File: rtl/note_ram.sv
// ---------------------------------------------------------------------------
// note_ram
// DEPTH x W note table, synchronous write and registered read (1-clk latency).
// Contents are deliberately not reset.
//   clk_i    : clock
//   we_i     : write strobe
//   waddr_i  : write address
//   wdata_i  : write data {pitch, duration}
//   raddr_i  : read address
//   rdata_o  : read data, valid the clk after raddr_i is presented
// ---------------------------------------------------------------------------
module note_ram #(
    parameter int unsigned DEPTH = 32,
    parameter int unsigned AW    = 5,
    parameter int unsigned W     = 18
) (
    input  logic          clk_i,
    input  logic          we_i,
    input  logic [AW-1:0] waddr_i,
    input  logic [W-1:0]  wdata_i,
    input  logic [AW-1:0] raddr_i,
    output logic [W-1:0]  rdata_o
);

    logic [W-1:0] mem_q [DEPTH];
    logic [W-1:0] rdata_q;

    always_ff @(posedge clk_i) begin
        if (we_i) begin
            mem_q[waddr_i] <= wdata_i;
        end
        rdata_q <= mem_q[raddr_i];
    end

    assign rdata_o = rdata_q;

endmodule

// File: rtl/melody_sequencer.sv
// ---------------------------------------------------------------------------
// melody_sequencer
// Plays a host-loaded note table (pitch divider + duration in fs samples)
// once or in a loop, driving the sine clkgen divider value and gating the
// tone. Each note's last GAP samples are muted for articulation.
//   clk          : system clock
//   reset        : asynchronous active-low reset
//   sample_tick  : one-clk pulse at fs
//   wr_en/wr_addr/wr_pitch/wr_dur : note table write port (IDLE only)
//   num_notes    : table length used for playback (latched at start)
//   loop_en      : restart at entry 0 after the last note (latched at start)
//   start / stop : begin playback (IDLE only) / abort playback
//   pitch_maxval : divider value for the sine clkgen
//   tone_en      : 1 = sound, 0 = mute
//   note_idx     : index of the current note
//   busy         : high while playing (FETCH/PLAY/DONE)
//   done         : one-clk pulse when non-loop playback completes
// ---------------------------------------------------------------------------
module melody_sequencer
    import tone_pkg::*;
#(
    parameter int unsigned DEPTH = 32,
    parameter int unsigned AW    = 5,
    parameter int unsigned PW    = PW_DEF,
    parameter int unsigned DW    = DW_DEF,
    parameter int unsigned GAP   = 200
) (
    input  logic          clk,
    input  logic          reset,
    input  logic          sample_tick,
    input  logic          wr_en,
    input  logic [AW-1:0] wr_addr,
    input  logic [PW-1:0] wr_pitch,
    input  logic [DW-1:0] wr_dur,
    input  logic [AW:0]   num_notes,
    input  logic          loop_en,
    input  logic          start,
    input  logic          stop,
    output logic [PW-1:0] pitch_maxval,
    output logic          tone_en,
    output logic [AW-1:0] note_idx,
    output logic          busy,
    output logic          done
);

    seq_state_e    state_q;
    logic [AW-1:0] idx_q, idx_d;
    logic [AW:0]   len_q;
    logic          loop_q;
    logic [PW-1:0] cur_pitch_q;
    logic [DW-1:0] cur_dur_q;
    logic [DW-1:0] cnt_q;
    logic [PW-1:0] pitch_q;
    logic          tone_q;
    logic          busy_q;
    logic          done_q;

    logic [PW+DW-1:0] rd_data;
    logic [PW-1:0]    rd_pitch;
    logic [DW-1:0]    rd_dur;
    logic [DW-1:0]    fetch_dur;
    logic             start_ok;
    logic             note_end;
    logic             last_note;

    // Sound while the pitch is not a rest and the sample count is outside the
    // trailing articulation gap; notes no longer than the gap sound throughout.
    function automatic logic sound(input logic [PW-1:0] p,
                                   input logic [DW-1:0] d,
                                   input logic [DW-1:0] c);
        return (p != '0) && ((d <= DW'(GAP)) || (c < (d - DW'(GAP))));
    endfunction

    note_ram #(
        .DEPTH (DEPTH),
        .AW    (AW),
        .W     (PW + DW)
    ) u_note_ram (
        .clk_i   (clk),
        .we_i    (wr_en && (state_q == ST_IDLE)),
        .waddr_i (wr_addr),
        .wdata_i ({wr_pitch, wr_dur}),
        .raddr_i (idx_d),
        .rdata_o (rd_data)
    );

    assign rd_pitch  = rd_data[PW+DW-1:DW];
    assign rd_dur    = rd_data[DW-1:0];
    assign fetch_dur = (rd_dur == '0) ? DW'(1) : rd_dur;

    assign start_ok  = start && !stop && (num_notes != '0);
    assign note_end  = sample_tick && (cnt_q == (cur_dur_q - DW'(1)));
    assign last_note = (({1'b0, idx_q} + (AW+1)'(1)) >= len_q);

    // The RAM is addressed with the next index so the entry is already on
    // rd_data during the single FETCH clk, giving the 1-clk FETCH state.
    always_comb begin
        idx_d = idx_q;
        case (state_q)
            ST_IDLE: begin
                if (start_ok) begin
                    idx_d = '0;
                end
            end
            ST_PLAY: begin
                if (!stop && note_end) begin
                    if (!last_note) begin
                        idx_d = idx_q + AW'(1);
                    end else if (loop_q) begin
                        idx_d = '0;
                    end
                end
            end
            default: idx_d = idx_q;
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q     <= ST_IDLE;
            idx_q       <= '0;
            len_q       <= '0;
            loop_q      <= 1'b0;
            cur_pitch_q <= '0;
            cur_dur_q   <= '0;
            cnt_q       <= '0;
            pitch_q     <= '0;
            tone_q      <= 1'b0;
            busy_q      <= 1'b0;
            done_q      <= 1'b0;
        end else begin
            idx_q  <= idx_d;
            done_q <= 1'b0;
            if (stop && (state_q != ST_IDLE)) begin
                state_q <= ST_IDLE;
                tone_q  <= 1'b0;
                busy_q  <= 1'b0;
            end else begin
                case (state_q)
                    ST_IDLE: begin
                        if (start_ok) begin
                            len_q   <= num_notes;
                            loop_q  <= loop_en;
                            busy_q  <= 1'b1;
                            state_q <= ST_FETCH;
                        end
                    end
                    ST_FETCH: begin
                        cur_pitch_q <= rd_pitch;
                        cur_dur_q   <= fetch_dur;
                        // A rest keeps the previous divider value so the
                        // downstream clkgen never sees a glitch.
                        if (rd_pitch != '0) begin
                            pitch_q <= rd_pitch;
                        end
                        cnt_q   <= '0;
                        tone_q  <= sound(rd_pitch, fetch_dur, '0);
                        state_q <= ST_PLAY;
                    end
                    ST_PLAY: begin
                        if (sample_tick) begin
                            if (note_end) begin
                                tone_q <= 1'b0;
                                if (!last_note || loop_q) begin
                                    state_q <= ST_FETCH;
                                end else begin
                                    state_q <= ST_DONE;
                                    done_q  <= 1'b1;
                                end
                            end else begin
                                cnt_q  <= cnt_q + DW'(1);
                                tone_q <= sound(cur_pitch_q, cur_dur_q, cnt_q + DW'(1));
                            end
                        end
                    end
                    ST_DONE: begin
                        busy_q  <= 1'b0;
                        state_q <= ST_IDLE;
                    end
                    default: state_q <= ST_IDLE;
                endcase
            end
        end
    end

    assign pitch_maxval = pitch_q;
    assign tone_en      = tone_q;
    assign note_idx     = idx_q;
    assign busy         = busy_q;
    assign done         = done_q;

endmodule
